// File: rtl/nand_status_reader_pkg.sv
// Shared NAND definitions: status-poll FSM encoding, status-register bit
// positions and the status command opcode.
package nand_status_reader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWhr,
        StReLo,
        StReHi,
        StFin
    } state_e;

    // Bit positions within the NAND status register
    localparam int unsigned StatusFailBit = 0;
    localparam int unsigned StatusArdyBit = 5;
    localparam int unsigned StatusRdyBit  = 6;
    localparam int unsigned StatusWpNBit  = 7;

    // Read Status command opcode, issued by the command path before start
    localparam logic [7:0] CmdReadStatus = 8'h70;

endpackage

// File: rtl/nand_status_reader.sv
// NAND status poller: after a 70h command, waits tWHR, then strobes RE_n
// repeatedly, sampling the status byte until RDY is set or the poll limit
// is reached. One down-counter times every phase.
module nand_status_reader
    import nand_status_reader_pkg::*;
#(
    parameter int unsigned TWHR_CYC    = 6,
    parameter int unsigned RE_LOW_CYC  = 3,
    parameter int unsigned RE_HIGH_CYC = 2,
    parameter int unsigned MAX_POLLS   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] io_in,
    output logic       re_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] status_byte,
    output logic       op_fail,
    output logic       timeout
);

    // Counter reload values: a phase of N cycles counts N-1 down to 0
    localparam logic [15:0] WhrLoad  = 16'(TWHR_CYC - 1);
    localparam logic [15:0] LoLoad   = 16'(RE_LOW_CYC - 1);
    localparam logic [15:0] HiLoad   = 16'(RE_HIGH_CYC - 1);
    localparam logic [15:0] MaxPolls = 16'(MAX_POLLS);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] poll_q, poll_d;
    logic        re_n_q, re_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  status_q, status_d;
    logic        op_fail_q, op_fail_d;
    logic        timeout_q, timeout_d;
    logic [15:0] poll_inc;

    assign poll_inc = poll_q + 16'd1;

    // Next-state logic; re_n_d is derived from the state being entered so the
    // registered strobe is low exactly while the FSM sits in StReLo.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        re_n_d    = 1'b1;
        busy_d    = busy_q;
        done_d    = 1'b0;
        status_d  = status_q;
        op_fail_d = op_fail_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StWhr;
                    cnt_d     = WhrLoad;
                    poll_d    = '0;
                    busy_d    = 1'b1;
                    op_fail_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            StWhr: begin
                if (cnt_q == '0) begin
                    state_d = StReLo;
                    cnt_d   = LoLoad;
                    re_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StReLo: begin
                re_n_d = 1'b0;
                if (cnt_q == '0) begin
                    status_d = io_in;
                    poll_d   = poll_inc;
                    re_n_d   = 1'b1;
                    // Ready wins over the poll limit on the same sample
                    if (io_in[StatusRdyBit]) begin
                        state_d   = StFin;
                        done_d    = 1'b1;
                        op_fail_d = io_in[StatusFailBit];
                    end else if (poll_inc == MaxPolls) begin
                        state_d   = StFin;
                        done_d    = 1'b1;
                        op_fail_d = io_in[StatusFailBit];
                        timeout_d = 1'b1;
                    end else begin
                        state_d = StReHi;
                        cnt_d   = HiLoad;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StReHi: begin
                if (cnt_q == '0) begin
                    state_d = StReLo;
                    cnt_d   = LoLoad;
                    re_n_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StFin: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            poll_q    <= '0;
            re_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= 8'h00;
            op_fail_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            re_n_q    <= re_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            status_q  <= status_d;
            op_fail_q <= op_fail_d;
            timeout_q <= timeout_d;
        end
    end

    assign re_n        = re_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign status_byte = status_q;
    assign op_fail     = op_fail_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_nand_status_reader.sv
// Directed bench for nand_status_reader: one instance with default
// parameters and one with MAX_POLLS=4 for the limit cases.
module tb_nand_status_reader;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_b;
    logic [7:0] io_in;

    logic       re_n_a, busy_a, done_a, op_fail_a, timeout_a;
    logic [7:0] status_a;
    logic       re_n_b, busy_b, done_b, op_fail_b, timeout_b;
    logic [7:0] status_b;

    int passed = 0;
    int total  = 0;

    localparam int MaxCycles = 200;

    nand_status_reader dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_a),
        .io_in       (io_in),
        .re_n        (re_n_a),
        .busy        (busy_a),
        .done        (done_a),
        .status_byte (status_a),
        .op_fail     (op_fail_a),
        .timeout     (timeout_a)
    );

    nand_status_reader #(.MAX_POLLS(4)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_b),
        .io_in       (io_in),
        .re_n        (re_n_b),
        .busy        (busy_b),
        .done        (done_b),
        .status_byte (status_b),
        .op_fail     (op_fail_b),
        .timeout     (timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one poll and measures the strobe waveform until shortly after done.
    // k counts negedges after the start negedge; delay is posedges from the
    // accepting edge to the first low RE_n. io_in switches to io_next on the
    // falling edge of pulse switch_after+1.
    task automatic run_poll(
        input  bit         sel4,
        input  logic [7:0] io_first,
        input  int         switch_after,
        input  logic [7:0] io_next,
        output int         pulses,
        output int         lo_min,
        output int         lo_max,
        output int         hi_min,
        output int         hi_max,
        output int         delay,
        output int         done_cycles,
        output int         done_k,
        output logic [7:0] sb,
        output logic       of,
        output logic       to,
        output logic [7:0] sb_n1,
        output logic       of_n1,
        output logic       to_n1,
        output logic       busy_n1,
        output logic       busy_after
    );
        int   lo_run, hi_run, post;
        logic prev, cur;
        bit   seen_done;
        pulses = 0; lo_min = 999; lo_max = 0; hi_min = 999; hi_max = 0;
        delay = -1; done_cycles = 0; done_k = -1; sb = 8'hxx; of = 1'bx; to = 1'bx;
        sb_n1 = 8'hxx; of_n1 = 1'bx; to_n1 = 1'bx; busy_n1 = 1'bx; busy_after = 1'bx;
        lo_run = 0; hi_run = 0; post = 0; prev = 1'b1; seen_done = 1'b0;
        @(negedge clk);
        io_in = io_first;
        if (sel4) start_b = 1'b1;
        else start_a = 1'b1;
        for (int k = 1; k <= MaxCycles; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            cur = sel4 ? re_n_b : re_n_a;
            if (k == 1) begin
                sb_n1   = sel4 ? status_b  : status_a;
                of_n1   = sel4 ? op_fail_b : op_fail_a;
                to_n1   = sel4 ? timeout_b : timeout_a;
                busy_n1 = sel4 ? busy_b    : busy_a;
            end
            if (prev && !cur) begin
                pulses++;
                if (pulses == 1) delay = k - 1;
                else begin
                    if (hi_run < hi_min) hi_min = hi_run;
                    if (hi_run > hi_max) hi_max = hi_run;
                end
                lo_run = 0;
                if (pulses == switch_after + 1) io_in = io_next;
            end
            if (!prev && cur) begin
                if (lo_run < lo_min) lo_min = lo_run;
                if (lo_run > lo_max) lo_max = lo_run;
                hi_run = 0;
            end
            if (!cur) lo_run++;
            else hi_run++;
            if (sel4 ? done_b : done_a) begin
                done_cycles++;
                if (!seen_done) begin
                    seen_done = 1'b1;
                    done_k    = k;
                    sb        = sel4 ? status_b  : status_a;
                    of        = sel4 ? op_fail_b : op_fail_a;
                    to        = sel4 ? timeout_b : timeout_a;
                end
            end
            if (seen_done) begin
                post++;
                if (post == 3) begin
                    busy_after = sel4 ? busy_b : busy_a;
                    break;
                end
            end
            prev = cur;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; io_in = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (re_n_a !== 1'b1) $display("FAIL reset_re_n: got %b want 1", re_n_a); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else passed++;
        total++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else passed++;
        total++; if (status_a !== 8'h00) $display("FAIL reset_status: got %h want 00", status_a); else passed++;
        total++; if (op_fail_a !== 1'b0) $display("FAIL reset_op_fail: got %b want 0", op_fail_a); else passed++;
        total++; if (timeout_a !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_a); else passed++;
        total++; if (re_n_b !== 1'b1 || busy_b !== 1'b0) $display("FAIL reset_b: got re_n=%b busy=%b want 1/0", re_n_b, busy_b); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_immediate_ready();
        int p, lmin, lmax, hmin, hmax, dly, dc, dk;
        logic [7:0] sb, sb1; logic of, to, of1, to1, b1, ba;
        run_poll(1'b0, 8'hE0, 99, 8'hE0, p, lmin, lmax, hmin, hmax, dly, dc, dk,
                 sb, of, to, sb1, of1, to1, b1, ba);
        total++; if (b1 !== 1'b1) $display("FAIL ready_busy_set: got %b want 1", b1); else passed++;
        total++; if (p !== 1) $display("FAIL ready_pulses: got %0d want 1", p); else passed++;
        total++; if (dly !== 6) $display("FAIL ready_twhr: got %0d want 6", dly); else passed++;
        total++; if (lmin !== 3 || lmax !== 3) $display("FAIL ready_lo_len: got %0d..%0d want 3", lmin, lmax); else passed++;
        total++; if (dk !== 10) $display("FAIL ready_done_time: got %0d want 10", dk); else passed++;
        total++; if (dc !== 1) $display("FAIL ready_done_width: got %0d want 1", dc); else passed++;
        total++; if (sb !== 8'hE0) $display("FAIL ready_status: got %h want e0", sb); else passed++;
        total++; if (of !== 1'b0 || to !== 1'b0) $display("FAIL ready_flags: got of=%b to=%b want 0/0", of, to); else passed++;
        total++; if (ba !== 1'b0) $display("FAIL ready_busy_clear: got %b want 0", ba); else passed++;
    endtask

    task automatic test_busy_then_ready();
        int p, lmin, lmax, hmin, hmax, dly, dc, dk;
        logic [7:0] sb, sb1; logic of, to, of1, to1, b1, ba;
        run_poll(1'b0, 8'h80, 4, 8'hC1, p, lmin, lmax, hmin, hmax, dly, dc, dk,
                 sb, of, to, sb1, of1, to1, b1, ba);
        total++; if (sb1 !== 8'hE0) $display("FAIL poll_status_held: got %h want e0", sb1); else passed++;
        total++; if (p !== 5) $display("FAIL poll_pulses: got %0d want 5", p); else passed++;
        total++; if (lmin !== 3 || lmax !== 3) $display("FAIL poll_lo_len: got %0d..%0d want 3", lmin, lmax); else passed++;
        total++; if (hmin !== 2 || hmax !== 2) $display("FAIL poll_hi_len: got %0d..%0d want 2", hmin, hmax); else passed++;
        total++; if (dk !== 30) $display("FAIL poll_done_time: got %0d want 30", dk); else passed++;
        total++; if (sb !== 8'hC1) $display("FAIL poll_status: got %h want c1", sb); else passed++;
        total++; if (of !== 1'b1 || to !== 1'b0) $display("FAIL poll_flags: got of=%b to=%b want 1/0", of, to); else passed++;
    endtask

    task automatic test_boundary();
        int p, lmin, lmax, hmin, hmax, dly, dc, dk;
        logic [7:0] sb, sb1; logic of, to, of1, to1, b1, ba;
        run_poll(1'b1, 8'h00, 3, 8'h41, p, lmin, lmax, hmin, hmax, dly, dc, dk,
                 sb, of, to, sb1, of1, to1, b1, ba);
        total++; if (p !== 4) $display("FAIL bound_pulses: got %0d want 4", p); else passed++;
        total++; if (sb !== 8'h41) $display("FAIL bound_status: got %h want 41", sb); else passed++;
        total++; if (to !== 1'b0 || of !== 1'b1) $display("FAIL bound_flags: got to=%b of=%b want 0/1", to, of); else passed++;
        total++; if (dk !== 25) $display("FAIL bound_done_time: got %0d want 25", dk); else passed++;
    endtask

    task automatic test_timeout();
        int p, lmin, lmax, hmin, hmax, dly, dc, dk;
        logic [7:0] sb, sb1; logic of, to, of1, to1, b1, ba;
        run_poll(1'b1, 8'h00, 99, 8'h00, p, lmin, lmax, hmin, hmax, dly, dc, dk,
                 sb, of, to, sb1, of1, to1, b1, ba);
        total++; if (of1 !== 1'b0) $display("FAIL tmo_op_fail_cleared: got %b want 0", of1); else passed++;
        total++; if (sb1 !== 8'h41) $display("FAIL tmo_status_held: got %h want 41", sb1); else passed++;
        total++; if (p !== 4) $display("FAIL tmo_pulses: got %0d want 4", p); else passed++;
        total++; if (dk !== 25) $display("FAIL tmo_done_time: got %0d want 25", dk); else passed++;
        total++; if (to !== 1'b1) $display("FAIL tmo_flag: got %b want 1", to); else passed++;
        total++; if (sb !== 8'h00 || of !== 1'b0) $display("FAIL tmo_status: got %h/%b want 00/0", sb, of); else passed++;
    endtask

    task automatic test_rearm_clears_timeout();
        int p, lmin, lmax, hmin, hmax, dly, dc, dk;
        logic [7:0] sb, sb1; logic of, to, of1, to1, b1, ba;
        run_poll(1'b1, 8'h40, 99, 8'h40, p, lmin, lmax, hmin, hmax, dly, dc, dk,
                 sb, of, to, sb1, of1, to1, b1, ba);
        total++; if (to1 !== 1'b0) $display("FAIL rearm_timeout_cleared: got %b want 0", to1); else passed++;
        total++; if (p !== 1 || sb !== 8'h40 || to !== 1'b0) $display("FAIL rearm_result: got p=%0d sb=%h to=%b want 1/40/0", p, sb, to); else passed++;
    endtask

    task automatic test_back_to_back();
        int fall_k, done1, done2, ndone;
        logic prev;
        fall_k = -1; done1 = -1; done2 = -1; ndone = 0; prev = 1'b1;
        @(negedge clk);
        io_in = 8'hE0;
        start_a = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_a = (k == 3) || (k == 11);
            if (prev && !re_n_a && fall_k < 0) fall_k = k;
            prev = re_n_a;
            if (done_a) begin
                ndone++;
                if (ndone == 1) done1 = k;
                else if (ndone == 2) done2 = k;
            end
            if (k == 12) begin
                total++; if (busy_a !== 1'b1) $display("FAIL b2b_accepted: got busy=%b want 1", busy_a); else passed++;
            end
        end
        start_a = 1'b0;
        total++; if (fall_k !== 7) $display("FAIL busy_start_ignored: got fall at %0d want 7", fall_k); else passed++;
        total++; if (done1 !== 10) $display("FAIL b2b_done1: got %0d want 10", done1); else passed++;
        total++; if (done2 !== 21 || ndone !== 2) $display("FAIL b2b_done2: got %0d (n=%0d) want 21 (n=2)", done2, ndone); else passed++;
    endtask

    task automatic test_reset_mid_poll();
        int waited, ndone;
        waited = 0; ndone = 0;
        @(negedge clk);
        io_in = 8'h80;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        while (re_n_a !== 1'b0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        total++; if (re_n_a !== 1'b0) $display("FAIL midrst_reach_re_lo: got re_n=%b want 0", re_n_a); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (re_n_a !== 1'b1) $display("FAIL midrst_re_n: got %b want 1", re_n_a); else passed++;
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL midrst_busy_done: got %b/%b want 0/0", busy_a, done_a); else passed++;
        total++; if (status_a !== 8'h00 || op_fail_a !== 1'b0 || timeout_a !== 1'b0)
            $display("FAIL midrst_outputs: got %h/%b/%b want 00/0/0", status_a, op_fail_a, timeout_a); else passed++;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        total++; if (ndone !== 0 || re_n_a !== 1'b1) $display("FAIL midrst_quiet: got done=%0d re_n=%b want 0/1", ndone, re_n_a); else passed++;
    endtask

    initial begin
        test_reset();
        test_immediate_ready();
        test_busy_then_ready();
        test_boundary();
        test_timeout();
        test_rearm_clears_timeout();
        test_back_to_back();
        test_reset_mid_poll();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nand_status_reader.md
NAND_STATUS_READER -- requirements
Module: nand_status_reader

Interface
REQ-001 Parameter TWHR_CYC, default 6: clk cycles waited between start and the first RE_n falling edge.
REQ-002 Parameter RE_LOW_CYC, default 3: RE_n low time in clk cycles; must be at least 2.
REQ-003 Parameter RE_HIGH_CYC, default 2: RE_n high time between poll pulses, in clk cycles.
REQ-004 Parameter MAX_POLLS, default 1024: maximum status reads before timeout; 16-bit counter.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset; synchronous and active-low.
REQ-007 start  input  1  one-cycle pulse, asserted by the command path after it drives 8'h70 (status command).
REQ-008 io_in  input  8  NAND IO bus as seen by the controller.
REQ-009 re_n  output  1  NAND read-enable strobe.
REQ-010 busy  output  1  high while any status read is in progress.
REQ-011 done  output  1  one-cycle pulse when the poll completes, either ready or timeout.
REQ-012 status_byte  output  8  last sampled status value; held until the next start.
REQ-013 op_fail  output  1  copy of status bit 0 (FAIL) at done; held.
REQ-014 timeout  output  1  high at done if MAX_POLLS reads completed without ready; held.

Function
REQ-015 FSM states SHALL be IDLE, WHR, RE_LO, RE_HI, FIN.
REQ-016 In IDLE, start=1 SHALL clear the poll and cycle counters, set busy, and enter WHR on the next cycle.
REQ-017 WHR SHALL hold re_n=1 for TWHR_CYC cycles, then enter RE_LO.
REQ-018 RE_LO SHALL drive re_n=0 for RE_LO_CYC cycles.
REQ-019 io_in SHALL be registered into status_byte on the last RE_LO cycle; the poll counter increments on that same cycle.
REQ-020 From RE_LO, if the sampled bit 6 (RDY) is 1, the FSM SHALL enter FIN.
REQ-021 From RE_LO, if RDY is 0 and the poll count equals MAX_POLLS, the FSM SHALL set timeout and enter FIN.
REQ-022 Otherwise RE_LO SHALL enter RE_HI, which holds re_n=1 for RE_HIGH_CYC cycles and then returns to RE_LO.
REQ-023 Repeated polls SHALL NOT reissue the 70h command; the NAND outputs updated status on each RE_n pulse.
REQ-024 FIN SHALL last one cycle: done=1, op_fail=status_byte[0], re_n=1; the FSM then enters IDLE and busy clears.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 start on the cycle after done SHALL be accepted.
REQ-027 When RDY and the poll-limit condition coincide on the same sample, ready SHALL take priority and timeout=0.
REQ-028 timeout and op_fail SHALL clear on an accepted start.
REQ-029 status_byte SHALL be unchanged by an accepted start until the first new sample.
REQ-030 re_n SHALL be registered and glitch-free; it goes low only in RE_LO.

Reset
REQ-031 When rst_n=0 at a clk edge, the block SHALL set: FSM=IDLE, re_n=1, busy=0, done=0, status_byte=8'h00, op_fail=0, timeout=0, counters=0.
REQ-032 Reset mid-poll SHALL release re_n high on the next edge; no done pulse is produced.

Structure
REQ-033 State encoding and the status-bit indices SHALL reside in the shared NAND package: RDY=6, ARDY=5, WP_N=7, FAIL=0, together with the command constant 8'h70.
REQ-034 The block SHALL be one module with no submodules; a single down-counter serves all phase timing.

Verification
REQ-035 Immediate ready: start with io_in=8'hE0 (defaults) -> one re_n low pulse of 3 cycles, starting 6 cycles after start; done with status_byte=E0, op_fail=0, timeout=0.
REQ-036 Busy then ready: io_in=8'h80 for 4 pulses, then 8'hC1 -> exactly 5 re_n pulses, each separated by 2 high cycles; done with op_fail=1.
REQ-037 Timeout: MAX_POLLS=4, io_in fixed at 8'h00 -> 4 pulses; done with timeout=1 and status_byte=00.
REQ-038 Boundary: MAX_POLLS=4, RDY first appears on the 4th sample -> timeout=0.
REQ-039 start while busy -> ignored; back-to-back start the cycle after done -> accepted.
REQ-040 rst_n low during RE_LO -> re_n=1 next cycle, all outputs at reset values, no done pulse.
